// File: rtl/clken_pkg.sv
// Shared constants and elaboration-time helpers for the fractional clock-enable generator.
package clken_pkg;

   localparam int CLKEN_W_DEF = 16;
   localparam int MAX_N       = 16;
   localparam int MAX_W       = 32;
   localparam int VEC_W       = MAX_N * MAX_W;

   // Legal channel: 0 < num <= den < 2^(w-1), 0 <= phase < den.
   function automatic bit clken_check(input longint num, input longint den,
                                      input longint phase, input int w);
      return (num > 0) && (num <= den) && (den < (longint'(1) << (w - 1)))
             && (phase >= 0) && (phase < den);
   endfunction

   // Extracts field i of width w from a packed per-channel vector.
   function automatic logic [MAX_W-1:0] clken_field(input logic [VEC_W-1:0] vec,
                                                    input int i, input int w);
      logic [MAX_W-1:0] f;
      f = '0;
      for (int b = 0; b < MAX_W; b++) begin
         if (b < w) f[b] = vec[i*w + b];
      end
      return f;
   endfunction

endpackage

// File: rtl/clken_frac_gen_nco.sv
// One NCO channel: phase accumulator producing a single-cycle enable and a toggle.
module clken_nco
   import clken_pkg::*;
#(
   parameter int         W     = CLKEN_W_DEF,
   parameter logic [W-1:0] NUM = 1,
   parameter logic [W-1:0] DEN = 2,
   parameter logic [W-1:0] PHASE = 0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic run_i,
   input  logic sync_i,
   output logic ce_o,
   output logic tog_o
);

   if (!clken_check(longint'(NUM), longint'(DEN), longint'(PHASE), W)) begin : g_bad_cfg
      $error("clken_nco: illegal NUM/DEN/PHASE for W=%0d", W);
   end

   logic [W-1:0] acc_q, acc_d;
   logic         ce_q, ce_d;
   logic         tog_q, tog_d;
   logic [W:0]   sum, diff;

   // Both candidates computed in parallel; the sign of s-DEN selects the wrap.
   always_comb begin
      sum  = {1'b0, acc_q} + {1'b0, NUM};
      diff = sum - {1'b0, DEN};
   end

   // Next state: hold at PHASE while not running, reload on sync, else accumulate.
   always_comb begin
      acc_d = acc_q;
      ce_d  = 1'b0;
      tog_d = tog_q;
      if (!run_i) begin
         acc_d = PHASE;
      end else if (sync_i) begin
         acc_d = PHASE;
         tog_d = 1'b0;
      end else if (!diff[W]) begin
         acc_d = diff[W-1:0];
         ce_d  = 1'b1;
         tog_d = ~tog_q;
      end else begin
         acc_d = sum[W-1:0];
      end
   end

   // Channel registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         acc_q <= PHASE;
         ce_q  <= 1'b0;
         tog_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         ce_q  <= ce_d;
         tog_q <= tog_d;
      end
   end

   assign ce_o  = ce_q;
   assign tog_o = tog_q;

endmodule

// File: rtl/clken_frac_gen.sv
// N-channel fractional clock-enable generator with settling delay and phase resync.
module clken_frac_gen
   import clken_pkg::*;
#(
   parameter int             N           = 4,
   parameter int             W           = CLKEN_W_DEF,
   parameter logic [N*W-1:0] NUM         = {16'd16, 16'd24, 16'd4, 16'd24},
   parameter logic [N*W-1:0] DEN         = {4{16'd25}},
   parameter logic [N*W-1:0] PHASE       = '0,
   parameter int             LOCK_CYCLES = 16
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         sync_i,
   output logic [N-1:0] ce_o,
   output logic [N-1:0] tog_o,
   output logic         locked_o
);

   if (N < 1 || N > MAX_N || W < 2 || W > MAX_W || LOCK_CYCLES < 1) begin : g_bad_top
      $error("clken_frac_gen: illegal N=%0d W=%0d LOCK_CYCLES=%0d", N, W, LOCK_CYCLES);
   end

   localparam int CW = $clog2(LOCK_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          locked_q, locked_d;

   // Saturating settling counter; locked compares the value being loaded so it
   // rises on the LOCK_CYCLES-th edge out of reset.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != CW'(LOCK_CYCLES)) cnt_d = cnt_q + CW'(1);
      locked_d = (cnt_d == CW'(LOCK_CYCLES));
   end

   // Lock sequencing registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q    <= '0;
         locked_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         locked_q <= locked_d;
      end
   end

   assign locked_o = locked_q;

   for (genvar i = 0; i < N; i++) begin : g_ch
      localparam logic [MAX_W-1:0] NUM_F = clken_field(VEC_W'(NUM), i, W);
      localparam logic [MAX_W-1:0] DEN_F = clken_field(VEC_W'(DEN), i, W);
      localparam logic [MAX_W-1:0] PH_F  = clken_field(VEC_W'(PHASE), i, W);

      clken_nco #(
         .W     (W),
         .NUM   (NUM_F[W-1:0]),
         .DEN   (DEN_F[W-1:0]),
         .PHASE (PH_F[W-1:0])
      ) u_nco (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .run_i   (locked_q),
         .sync_i  (sync_i),
         .ce_o    (ce_o[i]),
         .tog_o   (tog_o[i])
      );
   end

endmodule

// File: doc/clken_frac_gen.md
# clken_frac_gen

Parametrised fractional clock-enable generator that derives N independent rate channels from one system clock. Each channel uses an NCO-style accumulator that produces exact average rates such as 48/8/32 MHz enables from 50 MHz. It extends the fixed multi-output clock source with these features:
- a runtime phase-resync input;
- per-channel initial phase;
- a lock/ready indication after a programmable settling delay.

Downstream logic stays in one clock domain and qualifies its registers with `ce[i]`.

## Interface
- `N`, default 4: number of channels, 1..16.
- `W`, default 16: accumulator width, in bits.
- `NUM`, default {16'd16,16'd24,16'd4,16'd24}: packed N×W per-channel numerators. Channel i uses `NUM[i*W +: W]`.
- `DEN`, default {4{16'd25}}: packed N×W per-channel denominators.
- `PHASE`, default all 0: packed N×W initial accumulator values, with `PHASE[i] < DEN[i]`.
- `LOCK_CYCLES`, default 16: number of cycles from reset release to `locked`, ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sync`  in  1  phase resync request. When high for a cycle while locked, all accumulators reload to `PHASE`.
- `ce`  out  N  per-channel clock-enable. Each bit is a single-cycle pulse.
- `tog`  out  N  per-channel toggle. Each bit inverts on every `ce[i]` pulse, giving a 50%-ish square wave at `NUM/(2·DEN)·f_clk`.
- `locked`  out  1  high once the settling delay has elapsed. Channels run only while `locked` is high.

## Operation
- Legality:
  - Required: `0 < NUM[i] ≤ DEN[i] < 2^(W-1)`.
  - A violation is an elaboration error (assertion in the package function).
- Reset (`rst_n`=0 at a clk edge):
  - `acc[i]` ← `PHASE[i]`.
  - `ce` ← 0, `tog` ← 0, `locked` ← 0.
  - Lock counter ← 0.
  - Reset overrides `sync` and all other activity, including mid-run.
- Lock sequencing:
  - The counter increments on each edge with `rst_n`=1 until it reaches `LOCK_CYCLES`, then saturates.
  - `locked` is a registered compare (`count == LOCK_CYCLES`) and stays high until the next reset.
- Channel update, per edge while `locked`=1 and `sync`=0:
  - `s = acc[i] + NUM[i]`, computed in W+1 bits.
  - If `s ≥ DEN[i]`: `acc[i]` ← `s − DEN[i]`, `ce[i]` ← 1, `tog[i]` ← ~`tog[i]`.
  - Otherwise: `acc[i]` ← `s`, `ce[i]` ← 0.
- While `locked`=0:
  - `acc` is held at `PHASE`.
  - `ce` = 0 and `tog` is held.
- Resync (`sync`=1 while `locked`=1):
  - `acc[i]` ← `PHASE[i]` and `ce` ← 0 on that edge.
  - `tog` ← 0, so all toggles are phase-aligned.
  - Holding `sync` high keeps channels frozen.
  - Normal update resumes on the first edge with `sync`=0.
  - `sync` has no effect while `locked`=0.
- Rate guarantee: over any window of `DEN[i]` consecutive running cycles, channel i produces exactly `NUM[i]` `ce` pulses.
- `NUM`=`DEN`: `ce[i]` is constantly high while running.
- Channels are fully independent; there is no cross-channel arbitration.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `locked` rises on the `LOCK_CYCLES`-th edge after the first edge with `rst_n`=1.
- First channel update occurs on the edge after `locked` rises.
- Example: `PHASE`=0, 24/25. The first update leaves `acc`=24 with `ce`=0; the second edge gives `ce`=1 with `acc`=23. The first `ce` pulse is therefore visible 2 cycles after `locked`.
- `sync`: sampled at an edge. `ce` is 0 in the following cycle; the first post-sync pulse timing matches the post-lock timing.
- Critical path: one W+1-bit add plus compare/subtract per channel. Both `s` and `s−DEN` are computed in parallel and selected by the sign of `s−DEN`.

## Structure
- Package `clken_pkg`:
  - default `W`;
  - `MAX_N` = 16;
  - function `clken_check(num, den, phase, w)` returning a bit, used in the generate-time assertion;
  - helper function `clken_field(vec, i, w)` for packed-slice extraction.
- Sub-module `clken_nco`:
  - one channel holding `acc`, `ce`, `tog`;
  - inputs `clk`, `rst_n`, `run`, `sync`;
  - parameters `W`, `NUM`, `DEN`, `PHASE`.
- Top `clken_frac_gen`: the lock counter plus a generate loop of N `clken_nco` instances.

## Test plan
- Reset/lock:
  - Stimulus: hold `rst_n`=0 for 5 cycles, then release, with `LOCK_CYCLES`=16.
  - Response: `ce`=0, `tog`=0 and `locked`=0 throughout reset; `locked` rises exactly 16 edges after release; no `ce` pulse before `locked`.
- Rate:
  - Stimulus: default parameters, run 2500 cycles after lock.
  - Response: exactly 2400, 400, 2400 and 1600 pulses on ch0..ch3. In every 25-cycle window, 24/4/24/16 pulses respectively.
- Edge ratios:
  - Stimulus: `NUM`=`DEN`=7 and `NUM`=1, `DEN`=7.
  - Response: `ce` constantly 1 while running, and 1 pulse every 7 cycles respectively.
- Phase:
  - Stimulus: ch0 and ch1 both 1/4, with `PHASE`=0 and 3 respectively.
  - Response: ch1 pulses on the 1st update, ch0 on the 4th.
- Resync:
  - Stimulus: pulse `sync` for 1 cycle mid-run, then hold it for 10 cycles.
  - Response: `ce`=0 and `tog`=0 after the sync edge. Pulse sequence restarts identically to the post-lock sequence. No pulses while `sync` is held.
- Mid-run reset:
  - Stimulus: assert `rst_n`=0 for 1 cycle during a `ce` pulse, optionally with `sync`=1 at the same time.
  - Response: all outputs are 0 on the next cycle; the lock delay is re-run in full; `sync` during reset has no effect.
